mux_sel_sequencer: RTL

//  Upstream controller for the 4:1 mux stage: steps the select lines through all four inputs,

---
 rtl/mux_seq_pkg.sv | 23 ++
 rtl/mux_sel_sequencer_settle_timer.sv | 40 ++++
 rtl/mux_sel_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer: state encoding, select codes
// and the settle counter width.
package mux_seq_pkg;

    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    function automatic logic is_busy(input state_e st);
        return (st == SETTLE) || (st == SAMPLE);
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_settle_timer.sv
// Down-counter for the settle interval: loadable, decrements on request, and
// flags the last settle cycle (count == 1) so the FSM can move to SAMPLE.
module settle_timer
    import mux_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                expired_o
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Next count: load wins over decrement; never underflows below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {SETTLE_W{1'b0}})) begin
            cnt_d = cnt_q - {{(SETTLE_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {SETTLE_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {{(SETTLE_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mux_sel_sequencer.sv
// Scans a 4:1 mux: steps {s2,s1} through 00..11, waits SETTLE_CYCLES per select,
// samples f_i into result_o[select], and pulses done_o when all four are captured.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       f_i,
    output logic       s1_o,
    output logic       s2_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] result_o
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
    // With no settle time each select goes straight to its sampling cycle.
    localparam state_e FIRST_ST = (SETTLE_LD != 4'd0) ? SETTLE : SAMPLE;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [1:0]          sel_q, sel_d;
    logic [3:0]          result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tmr_load_s;
    logic [SETTLE_W-1:0] tmr_val_s;
    logic                tmr_dec_s;
    logic                tmr_exp_s;

    settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .expired_o  (tmr_exp_s)
    );

    // Next-state, select, index and capture logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        result_d   = result_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = SETTLE_LD;
        tmr_dec_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d      = SEL_A;
                    sel_d      = SEL_A;
                    tmr_load_s = 1'b1;
                    state_d    = FIRST_ST;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (abort_i) begin
                    state_d    = IDLE;
                    idx_d      = SEL_A;
                    sel_d      = SEL_A;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = {SETTLE_W{1'b0}};
                end else if (tmr_exp_s) begin
                    tmr_dec_s = 1'b1;
                    state_d   = SAMPLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            SAMPLE: begin
                // Abort beats capture: the bit for the current select is left untouched.
                if (abort_i) begin
                    state_d    = IDLE;
                    idx_d      = SEL_A;
                    sel_d      = SEL_A;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = {SETTLE_W{1'b0}};
                end else begin
                    result_d[idx_q] = f_i;
                    if (idx_q == SEL_D) begin
                        sel_d   = SEL_A;
                        state_d = DONE;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        sel_d      = idx_q + 2'd1;
                        tmr_load_s = 1'b1;
                        state_d    = FIRST_ST;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = is_busy(state_d);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= SEL_A;
            sel_q    <= SEL_A;
            result_q <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign s1_o     = sel_q[0];
    assign s2_o     = sel_q[1];
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
